// File: rtl/cordic_mac_seq.sv
// cordic_mac_seq: buffers operand pairs in a small FIFO, issues them one at a
// time to the CORDIC multiplier and accumulates the products into a wide
// signed sum that is emitted when the pair tagged `last` completes.
module cordic_mac_seq #(
    parameter int N     = 16,
    parameter int ACC_W = N + 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     mult_a,
    output logic [N-1:0]     mult_b,
    output logic             mult_start,
    input  logic [N-1:0]     mult_c,
    input  logic             mult_rdy,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    output logic             sum_ovf,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * N + 1;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FIFO storage and pointers; the extra pointer MSB separates full from empty
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    // Datapath registers
    logic [N-1:0]     r_mult_a;
    logic [N-1:0]     r_mult_b;
    logic             r_cur_last;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf_sticky;
    logic [ACC_W-1:0] r_sum;
    logic             r_sum_valid;
    logic             r_sum_ovf;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_now;
    logic             w_accum;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == StIdle) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Products are accepted only while waiting; stray rdy pulses are dropped
    assign w_accum    = (r_state == StWait) && mult_rdy;
    assign w_prod_ext = {{(ACC_W - N){mult_c[N-1]}}, mult_c};
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_ovf_now  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_acc_next[ACC_W-1] != r_acc[ACC_W-1]);

    assign in_ready   = !w_full;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign mult_start = (r_state == StIssue);
    assign sum        = r_sum;
    assign sum_valid  = r_sum_valid;
    assign sum_ovf    = r_sum_ovf;
    assign busy       = (r_state != StIdle) || !w_empty;

    // FIFO write port; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_last, in_a, in_b};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (!w_empty) w_state_next = StIssue;
            StIssue: w_state_next = StWait;
            StWait:  if (mult_rdy) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand latch, accumulator and group result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_cur_last   <= 1'b0;
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
            r_sum        <= '0;
            r_sum_valid  <= 1'b0;
            r_sum_ovf    <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_pop) begin
                r_cur_last <= w_head[EW-1];
                r_mult_a   <= w_head[2*N-1:N];
                r_mult_b   <= w_head[N-1:0];
            end
            if (w_accum) begin
                if (r_cur_last) begin
                    r_sum        <= w_acc_next;
                    r_sum_valid  <= 1'b1;
                    r_sum_ovf    <= r_ovf_sticky | w_ovf_now;
                    r_acc        <= '0;
                    r_ovf_sticky <= 1'b0;
                end else begin
                    r_acc        <= w_acc_next;
                    r_ovf_sticky <= r_ovf_sticky | w_ovf_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_mac_seq.sv
// Directed bench for cordic_mac_seq with a behavioural multiplier model that
// returns the truncated Q0.15 product about 8 cycles after mult_start.
module tb_cordic_mac_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic        mult_start;
    logic [15:0] mult_c;
    logic        mult_rdy;
    logic [19:0] sum;
    logic        sum_valid;
    logic        sum_ovf;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Multiplier model state (deliberately not reset so a late rdy can arrive)
    logic        m_rdy = 1'b0;
    logic [15:0] m_c = '0;
    logic [15:0] m_prod = '0;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic        stall = 1'b0;
    logic        stray_rdy = 1'b0;
    logic [15:0] stray_c = '0;

    int          starts = 0;
    int          valids = 0;
    logic [15:0] started_a [$];

    assign mult_rdy = m_rdy | stray_rdy;
    assign mult_c   = stray_rdy ? stray_c : m_c;

    cordic_mac_seq #(
        .N    (16),
        .ACC_W(20),
        .DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_start(mult_start),
        .mult_c    (mult_c),
        .mult_rdy  (mult_rdy),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ovf   (sum_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> 15;
        return p[15:0];
    endfunction

    // Multiplier model
    always @(posedge clk) begin
        m_rdy <= 1'b0;
        if (mult_start) begin
            m_pend <= 1'b1;
            m_cnt  <= 8;
            m_prod <= qmul(mult_a, mult_b);
        end else if (m_pend) begin
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (!stall) begin
                m_rdy  <= 1'b1;
                m_c    <= m_prod;
                m_pend <= 1'b0;
            end
        end
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (mult_start) begin
            starts = starts + 1;
            started_a.push_back(mult_a);
        end
        if (sum_valid) valids = valids + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a pair and complete the handshake; leaves in_valid high
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic last);
        int guard;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_sum(input string tag, input logic [19:0] exp_sum, input logic exp_ovf);
        int i;
        for (i = 0; i < 400; i++) begin
            if (sum_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, {31'd0, sum_valid}, 32'd1);
        check({tag, "_sum"}, {12'd0, sum}, {12'd0, exp_sum});
        check({tag, "_ovf"}, {31'd0, sum_ovf}, {31'd0, exp_ovf});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, sum_valid}, 32'd0);
    endtask

    initial begin
        int s0;
        int v0;
        int guard;
        bit dropped;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {12'd0, sum}, 32'd0);
        check("rst_start", {31'd0, mult_start}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mult_a", {16'd0, mult_a}, 32'd0);

        // Single pair with latency checks
        s0 = starts;
        v0 = valids;
        push(16'h4000, 16'h4000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("single_start_early", {31'd0, mult_start}, 32'd0);
        @(negedge clk);
        check("single_start", {31'd0, mult_start}, 32'd1);
        check("single_mult_a", {16'd0, mult_a}, 32'h4000);
        wait_sum("single", 20'h02000, 1'b0);
        check("single_nstart", starts - s0, 1);
        check("single_nvalid", valids - v0, 1);

        // Group of three
        s0 = starts;
        push(16'h4000, 16'h4000, 1'b0);
        push(16'hC000, 16'h4000, 1'b0);
        push(16'h7FFF, 16'h7FFF, 1'b1);
        idle_in();
        wait_sum("group3", 20'h07FFE, 1'b0);
        check("group3_nstart", starts - s0, 3);

        // FIFO full with the multiplier stalled
        repeat (12) @(negedge clk);
        started_a.delete();
        stall = 1'b1;
        dropped = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_a = 16'(16'h0100 * (i + 1));
            in_b = 16'h4000;
            in_last = (i == 5);
            in_valid = 1'b1;
            if (!in_ready && !dropped) begin
                dropped = 1'b1;
                check("full_accepted", i, 5);
                stall = 1'b0;
            end
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) check("full_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
        end
        check("full_dropped", {31'd0, dropped}, 32'd1);
        stall = 1'b0;
        idle_in();
        wait_sum("full", 20'h00A80, 1'b0);
        check("full_nstart", started_a.size(), 6);
        for (int i = 0; i < 6 && i < started_a.size(); i++) begin
            check("full_order", {16'd0, started_a[i]}, 32'(16'h0100 * (i + 1)));
        end

        // Overflow across twenty pairs, then a clean pair
        for (int i = 0; i < 20; i++) push(16'h7FFF, 16'h7FFF, i == 19);
        idle_in();
        wait_sum("ovf", 20'h9FFD8, 1'b1);
        push(16'h4000, 16'h4000, 1'b1);
        idle_in();
        wait_sum("ovf_clear", 20'h02000, 1'b0);

        // Stray rdy while idle
        repeat (4) @(negedge clk);
        stray_c = 16'h1234;
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        check("stray_busy", {31'd0, busy}, 32'd0);
        push(16'h4000, 16'h4000, 1'b1);
        idle_in();
        wait_sum("stray", 20'h02000, 1'b0);

        // Reset while waiting on a product
        s0 = starts;
        push(16'h7FFF, 16'h7FFF, 1'b0);
        push(16'h4000, 16'h4000, 1'b0);
        idle_in();
        guard = 0;
        while (starts - s0 < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rstw_started", starts - s0, 2);
        repeat (3) @(negedge clk);
        check("rstw_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_sum", {12'd0, sum}, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_mult_b", {16'd0, mult_b}, 32'd0);
        check("rstw_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        v0 = valids;
        repeat (15) @(negedge clk);
        check("rstw_late_valid", valids - v0, 0);
        check("rstw_late_busy", {31'd0, busy}, 32'd0);
        check("rstw_late_sum", {12'd0, sum}, 32'd0);
        push(16'h4000, 16'h4000, 1'b0);
        push(16'h4000, 16'h2000, 1'b1);
        idle_in();
        wait_sum("rstw_after", 20'h03000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
